// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-setting controller for the decimal clockwork.
// Walks hour/minute/second fields on button pulses, edits a packed-BCD
// working copy with wrap-around, and drives the clockwork overwrite pair.
module clock_set_ctrl #(
   parameter int unsigned COMMIT_CYCLES  = 200_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_mode,
   input  logic        btn_inc,
   input  logic        btn_dec,
   input  logic [19:0] time_current,
   output logic [19:0] time_set,
   output logic        time_ow,
   output logic        editing,
   output logic [1:0]  field
);

   localparam int unsigned CW = (COMMIT_CYCLES  > 1) ? $clog2(COMMIT_CYCLES)  : 1;
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(COMMIT_CYCLES - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EDIT_H,
      S_EDIT_M,
      S_EDIT_S,
      S_COMMIT
   } state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [19:0]     r_time;
   logic [CW-1:0]   r_commit_cnt;
   logic [TW-1:0]   r_timeout_cnt;
   logic            r_time_ow;
   logic            r_editing;
   logic [1:0]      r_field;
   logic            w_time_ow;
   logic            w_editing;
   logic [1:0]      w_field;
   logic            w_inc;
   logic            w_dec;
   logic            w_any_btn;
   logic            w_in_edit;
   logic            w_timeout;

   // Hour: out-of-range loads (tens 3, or 2x with x>=3) wrap to 00 on increment
   function automatic logic [5:0] hour_inc(input logic [5:0] h);
      logic [1:0] t;
      logic [3:0] u;
      t = h[5:4];
      u = h[3:0];
      if ((t == 2'd3) || ((t == 2'd2) && (u >= 4'd3))) return '0;
      else if (u >= 4'd9)                              return {t + 2'd1, 4'd0};
      else                                             return {t, u + 4'd1};
   endfunction

   function automatic logic [5:0] hour_dec(input logic [5:0] h);
      logic [1:0] t;
      logic [3:0] u;
      t = h[5:4];
      u = h[3:0];
      if (h == 6'h00)     return 6'h23;
      else if (u == 4'd0) return {t - 2'd1, 4'd9};
      else                return {t, u - 4'd1};
   endfunction

   function automatic logic [6:0] ms_inc(input logic [6:0] v);
      logic [2:0] t;
      logic [3:0] u;
      t = v[6:4];
      u = v[3:0];
      if ((t >= 3'd6) || ((t == 3'd5) && (u >= 4'd9))) return '0;
      else if (u >= 4'd9)                              return {t + 3'd1, 4'd0};
      else                                             return {t, u + 4'd1};
   endfunction

   function automatic logic [6:0] ms_dec(input logic [6:0] v);
      logic [2:0] t;
      logic [3:0] u;
      t = v[6:4];
      u = v[3:0];
      if (v == 7'h00)     return 7'h59;
      else if (u == 4'd0) return {t - 3'd1, 4'd9};
      else                return {t, u - 4'd1};
   endfunction

   // Mode wins over inc/dec; inc together with dec cancels out
   assign w_inc     = btn_inc & ~btn_dec & ~btn_mode;
   assign w_dec     = btn_dec & ~btn_inc & ~btn_mode;
   assign w_any_btn = btn_mode | btn_inc | btn_dec;
   assign w_in_edit = (r_state == S_EDIT_H) || (r_state == S_EDIT_M) || (r_state == S_EDIT_S);
   assign w_timeout = (r_timeout_cnt == T_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (btn_mode) w_next_state = S_EDIT_H;
         S_EDIT_H: if (btn_mode) w_next_state = S_EDIT_M;
                   else if (w_timeout) w_next_state = S_COMMIT;
         S_EDIT_M: if (btn_mode) w_next_state = S_EDIT_S;
                   else if (w_timeout) w_next_state = S_COMMIT;
         S_EDIT_S: if (btn_mode || w_timeout) w_next_state = S_COMMIT;
         S_COMMIT: if (r_commit_cnt == '0) w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Output decode from the next state so registered outputs align with the state
   always_comb begin
      w_time_ow = 1'b1;
      w_editing = 1'b0;
      w_field   = 2'b00;
      case (w_next_state)
         S_IDLE:   w_time_ow = 1'b0;
         S_EDIT_H: begin w_editing = 1'b1; w_field = 2'b01; end
         S_EDIT_M: begin w_editing = 1'b1; w_field = 2'b10; end
         S_EDIT_S: begin w_editing = 1'b1; w_field = 2'b11; end
         default:  ;
      endcase
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_time_ow <= 1'b0;
         r_editing <= 1'b0;
         r_field   <= 2'b00;
      end else begin
         r_time_ow <= w_time_ow;
         r_editing <= w_editing;
         r_field   <= w_field;
      end
   end

   // Commit hold and edit inactivity counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_commit_cnt  <= '0;
         r_timeout_cnt <= '0;
      end else begin
         if ((w_next_state == S_COMMIT) && (r_state != S_COMMIT))
            r_commit_cnt <= C_LAST;
         else if ((r_state == S_COMMIT) && (r_commit_cnt != '0))
            r_commit_cnt <= r_commit_cnt - 1'b1;

         if (!w_in_edit || w_any_btn || (w_next_state != r_state))
            r_timeout_cnt <= '0;
         else if (!w_timeout)
            r_timeout_cnt <= r_timeout_cnt + 1'b1;
      end
   end

   // Edit register: load on edit entry, BCD step of the selected field
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_time <= '0;
      end else begin
         case (r_state)
            S_IDLE:   if (btn_mode) r_time <= time_current;
            S_EDIT_H: if (w_inc) r_time[19:14] <= hour_inc(r_time[19:14]);
                      else if (w_dec) r_time[19:14] <= hour_dec(r_time[19:14]);
            S_EDIT_M: if (w_inc) r_time[13:7] <= ms_inc(r_time[13:7]);
                      else if (w_dec) r_time[13:7] <= ms_dec(r_time[13:7]);
            S_EDIT_S: if (w_inc) r_time[6:0] <= ms_inc(r_time[6:0]);
                      else if (w_dec) r_time[6:0] <= ms_dec(r_time[6:0]);
            default:  ;
         endcase
      end
   end

   assign time_set = r_time;
   assign time_ow  = r_time_ow;
   assign editing  = r_editing;
   assign field    = r_field;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed testbench for clock_set_ctrl: field editing, BCD wrap, button
// priority, timeout, reset, and a slow-clock clockwork integration run.
module tb_clock_set_ctrl;

   logic        clk;
   logic        sclk;
   logic        rst_n;
   logic        btn_mode;
   logic        btn_inc;
   logic        btn_dec;
   logic [19:0] time_current;
   logic [19:0] time_set;
   logic        time_ow;
   logic        editing;
   logic [1:0]  field;

   logic [19:0] set2;
   logic        ow2;
   logic        editing2;
   logic [1:0]  field2;
   logic [19:0] cw;
   logic        cw_rst;

   int n_tests;
   int n_fail;

   clock_set_ctrl #(.COMMIT_CYCLES(4), .TIMEOUT_CYCLES(10)) u_dut (
      .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .btn_dec(btn_dec), .time_current(time_current), .time_set(time_set),
      .time_ow(time_ow), .editing(editing), .field(field)
   );

   clock_set_ctrl #(.COMMIT_CYCLES(20), .TIMEOUT_CYCLES(1000)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .btn_dec(btn_dec), .time_current(cw), .time_set(set2),
      .time_ow(ow2), .editing(editing2), .field(field2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Clockwork clock is 10x slower and offset so its edges never meet clk edges
   initial begin
      sclk = 1'b0;
      #3;
      forever #50 sclk = ~sclk;
   end

   function automatic logic [19:0] pk(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      return {h[5:0], m[6:0], s[6:0]};
   endfunction

   function automatic logic [7:0] binc(input logic [7:0] v);
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      else                return v + 8'd1;
   endfunction

   function automatic logic [19:0] tick_time(input logic [19:0] t);
      logic [7:0] h, m, s;
      h = {2'b00, t[19:14]};
      m = {1'b0, t[13:7]};
      s = {1'b0, t[6:0]};
      if (s == 8'h59) begin
         s = 8'h00;
         if (m == 8'h59) begin
            m = 8'h00;
            h = (h == 8'h23) ? 8'h00 : binc(h);
         end else begin
            m = binc(m);
         end
      end else begin
         s = binc(s);
      end
      return pk(h, m, s);
   endfunction

   // Behavioural clockwork: loads time_in while overwrite is high, else ticks
   always @(posedge sclk) begin
      if (cw_rst)   cw <= pk(8'h12, 8'h33, 8'h55);
      else if (ow2) cw <= set2;
      else          cw <= tick_time(cw);
   end

   task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic m, input logic i, input logic d);
      btn_mode = m;
      btn_inc  = i;
      btn_dec  = d;
      tick();
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      btn_dec  = 1'b0;
   endtask

   task automatic start_edit(input logic [19:0] t);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      time_current = t;
      pulse(1'b1, 1'b0, 1'b0);
      chk("load", time_set, t);
      chk("load_field", {18'd0, field}, 20'd1);
   endtask

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      btn_mode     = 1'b0;
      btn_inc      = 1'b0;
      btn_dec      = 1'b0;
      cw_rst       = 1'b1;
      time_current = pk(8'h23, 8'h48, 8'h00);
      tick();
      tick();
      chk("rst_set", time_set, 20'd0);
      chk("rst_ow", {19'd0, time_ow}, 20'd0);
      chk("rst_edit", {19'd0, editing}, 20'd0);
      chk("rst_field", {18'd0, field}, 20'd0);
      rst_n = 1'b1;

      // Inc in IDLE is ignored
      pulse(1'b0, 1'b1, 1'b0);
      chk("idle_inc_set", time_set, 20'd0);
      chk("idle_inc_ow", {19'd0, time_ow}, 20'd0);

      // Basic edit 23:48:00 -> 00:47:05
      pulse(1'b1, 1'b0, 1'b0);
      chk("b_field_h", {18'd0, field}, 20'd1);
      chk("b_ow", {19'd0, time_ow}, 20'd1);
      chk("b_edit", {19'd0, editing}, 20'd1);
      chk("b_load", time_set, pk(8'h23, 8'h48, 8'h00));
      pulse(1'b0, 1'b1, 1'b0);
      chk("b_h_wrap", time_set, pk(8'h00, 8'h48, 8'h00));
      pulse(1'b1, 1'b0, 1'b0);
      chk("b_field_m", {18'd0, field}, 20'd2);
      pulse(1'b0, 1'b0, 1'b1);
      chk("b_m_dec", time_set, pk(8'h00, 8'h47, 8'h00));
      pulse(1'b1, 1'b0, 1'b0);
      chk("b_field_s", {18'd0, field}, 20'd3);
      btn_inc = 1'b1;
      repeat (5) tick();
      btn_inc = 1'b0;
      chk("b_s_inc5", time_set, pk(8'h00, 8'h47, 8'h05));
      pulse(1'b1, 1'b0, 1'b0);
      chk("b_field_0", {18'd0, field}, 20'd0);
      chk("b_commit_edit", {19'd0, editing}, 20'd0);
      chk("b_commit_ow", {19'd0, time_ow}, 20'd1);
      repeat (3) tick();
      chk("b_ow_hold", {19'd0, time_ow}, 20'd1);
      tick();
      chk("b_ow_drop", {19'd0, time_ow}, 20'd0);
      chk("b_final", time_set, pk(8'h00, 8'h47, 8'h05));

      // Mode in first IDLE cycle after commit starts a new edit
      time_current = pk(8'h00, 8'h59, 8'h09);
      pulse(1'b1, 1'b0, 1'b0);
      chk("reenter_field", {18'd0, field}, 20'd1);
      chk("reenter_load", time_set, pk(8'h00, 8'h59, 8'h09));
      pulse(1'b0, 1'b0, 1'b1);
      chk("h_dec_00", time_set, pk(8'h23, 8'h59, 8'h09));

      // Hour increment boundaries
      start_edit(pk(8'h09, 8'h00, 8'h00));
      pulse(1'b0, 1'b1, 1'b0);
      chk("h_inc_09", time_set, pk(8'h10, 8'h00, 8'h00));
      for (int i = 0; i < 9; i++) pulse(1'b0, 1'b1, 1'b0);
      chk("h_inc_to_19", time_set, pk(8'h19, 8'h00, 8'h00));
      pulse(1'b0, 1'b1, 1'b0);
      chk("h_inc_19", time_set, pk(8'h20, 8'h00, 8'h00));
      pulse(1'b0, 1'b0, 1'b1);
      chk("h_dec_20", time_set, pk(8'h19, 8'h00, 8'h00));
      start_edit(pk(8'h10, 8'h00, 8'h00));
      pulse(1'b0, 1'b0, 1'b1);
      chk("h_dec_10", time_set, pk(8'h09, 8'h00, 8'h00));
      start_edit(pk(8'h2F, 8'h00, 8'h00));
      pulse(1'b0, 1'b1, 1'b0);
      chk("h_inc_2F", time_set, pk(8'h00, 8'h00, 8'h00));

      // Minute and second boundaries
      start_edit(pk(8'h12, 8'h00, 8'h09));
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b0, 1'b1);
      chk("m_dec_00", time_set, pk(8'h12, 8'h59, 8'h09));
      pulse(1'b0, 1'b1, 1'b0);
      chk("m_inc_59", time_set, pk(8'h12, 8'h00, 8'h09));
      start_edit(pk(8'h12, 8'h10, 8'h09));
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b0, 1'b1);
      chk("m_dec_10", time_set, pk(8'h12, 8'h09, 8'h09));
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      chk("s_inc_09", time_set, pk(8'h12, 8'h09, 8'h10));
      pulse(1'b0, 1'b1, 1'b1);
      chk("incdec_same", time_set, pk(8'h12, 8'h09, 8'h10));
      chk("incdec_field", {18'd0, field}, 20'd3);

      // Mode beats inc
      start_edit(pk(8'h05, 8'h00, 8'h00));
      pulse(1'b1, 1'b1, 1'b0);
      chk("modeinc_field", {18'd0, field}, 20'd2);
      chk("modeinc_hour", time_set, pk(8'h05, 8'h00, 8'h00));

      // Timeout: COMMIT exactly 10 cycles after the last pulse
      start_edit(pk(8'h07, 8'h00, 8'h00));
      pulse(1'b0, 1'b1, 1'b0);
      repeat (9) tick();
      chk("to_still_edit", {19'd0, editing}, 20'd1);
      tick();
      chk("to_commit_edit", {19'd0, editing}, 20'd0);
      chk("to_commit_ow", {19'd0, time_ow}, 20'd1);
      chk("to_kept", time_set, pk(8'h08, 8'h00, 8'h00));
      repeat (4) tick();
      chk("to_idle_ow", {19'd0, time_ow}, 20'd0);

      // Reset during EDIT_M, then during COMMIT
      start_edit(pk(8'h11, 8'h22, 8'h33));
      pulse(1'b1, 1'b0, 1'b0);
      chk("r_in_m", {18'd0, field}, 20'd2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rm_ow", {19'd0, time_ow}, 20'd0);
      chk("rm_set", time_set, 20'd0);
      chk("rm_field", {18'd0, field}, 20'd0);
      repeat (4) pulse(1'b1, 1'b0, 1'b0);
      chk("r_in_commit", {19'd0, time_ow}, 20'd1);
      chk("r_in_commit_f", {18'd0, field}, 20'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rc_ow", {19'd0, time_ow}, 20'd0);
      chk("rc_set", time_set, 20'd0);
      chk("rc_field", {18'd0, field}, 20'd0);
      tick();
      chk("rc_stay_idle", {19'd0, time_ow}, 20'd0);

      // Integration with slow clockwork: set 12:34:56
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(posedge sclk);
      #1;
      cw_rst = 1'b0;
      pulse(1'b1, 1'b0, 1'b0);
      chk("i_load", set2, pk(8'h12, 8'h33, 8'h55));
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      chk("i_set", set2, pk(8'h12, 8'h34, 8'h56));
      repeat (2) @(posedge sclk);
      #1;
      chk("i_frozen", cw, pk(8'h12, 8'h34, 8'h56));
      chk("i_editing", {19'd0, editing2}, 20'd1);
      @(posedge sclk);
      #1;
      chk("i_frozen2", cw, pk(8'h12, 8'h34, 8'h56));
      pulse(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 60; i++) begin
         if (!ow2) break;
         tick();
      end
      chk("i_ow_drop", {19'd0, ow2}, 20'd0);
      chk("i_cw_at_drop", cw, pk(8'h12, 8'h34, 8'h56));
      @(posedge sclk);
      #1;
      chk("i_run1", cw, pk(8'h12, 8'h34, 8'h57));
      @(posedge sclk);
      #1;
      chk("i_run2", cw, pk(8'h12, 8'h34, 8'h58));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-setting controller for the decimal clockwork. It takes debounced single-cycle button pulses and walks the user through hour, minute and second fields. It edits a BCD working copy of the time with wrap-around and drives the clockwork's `time_in`/`time_ow` pair. The clockwork is frozen on the edited value during editing, and the overwrite is held long enough after commit for the slower clockwork clock to sample it.

## Interface
- `COMMIT_CYCLES`, default 200 000 000: cycles `time_ow` stays high after the last field is confirmed. Must be at least 2 clockwork clock periods, in `clk` cycles.
- `TIMEOUT_CYCLES`, default 1 000 000 000: idle cycles in an edit state before an automatic commit.
- `clk` input 1: system clock. One clock domain only.
- `rst_n` input 1: reset, synchronous, active-low.
- `btn_mode` input 1: one-cycle pulse; enter edit mode, or advance to the next field.
- `btn_inc` input 1: one-cycle pulse; increment the selected field.
- `btn_dec` input 1: one-cycle pulse; decrement the selected field.
- `time_current` input 20: live time from the clockwork, `{hour[5:0], min[6:0], sec[6:0]}` packed BCD.
- `time_set` output 20: value driven to the clockwork `time_in`, same packing.
- `time_ow` output 1: overwrite request to the clockwork.
- `editing` output 1: high in every edit state.
- `field` output 2: selected field for display blinking. 00 none, 01 hour, 10 min, 11 sec.

## Operation
- States: IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT.
- IDLE:
  - `btn_mode` loads `time_current` into the edit register and moves to EDIT_H.
  - `btn_inc` and `btn_dec` are ignored.
- EDIT_H, EDIT_M, EDIT_S:
  - `btn_mode` advances H→M→S→COMMIT.
  - `btn_inc` / `btn_dec` modify only the selected field.
- COMMIT:
  - A down-counter runs from `COMMIT_CYCLES-1` to 0, then the state returns to IDLE.
  - All buttons are ignored in this state.
- Field arithmetic is pure BCD; binary carries never appear:
  - Hour: tens 2 bits, units 4 bits. Increment 09→10, 19→20, 23→00. Decrement 00→23, 20→19, 10→09.
  - Minute and second: tens 3 bits, units 4 bits. Increment 09→10, 59→00. Decrement 00→59, 10→09.
- Button priority in the same cycle:
  - `btn_mode` beats inc/dec; the inc/dec pulse is discarded.
  - `btn_inc` together with `btn_dec` and no mode: no change.
- Timeout:
  - A counter clears on any button pulse and on every state change.
  - If it reaches `TIMEOUT_CYCLES-1` in any edit state, the next state is COMMIT. The edited value is kept.
- `time_set` mirrors the edit register at all times, IDLE included; the clockwork ignores it while `time_ow`=0.
- `time_ow` = 1 in EDIT_H, EDIT_M, EDIT_S and COMMIT, 0 in IDLE. This freezes the clockwork on the edited value during editing.
- `time_current` is sampled only on the IDLE→EDIT_H transition. The value is assumed valid BCD; an out-of-range load (e.g. hour 2F) wraps to 00 on the first increment.

## Timing
- All outputs are registered.
- Reset values: state IDLE; `time_set`=0; `time_ow`=0; `editing`=0; `field`=00; both counters 0.
- Reset asserted mid-edit or mid-commit returns to IDLE on the next edge. `time_ow` drops in the same cycle and the edit is lost.
- `btn_mode` at edge n in IDLE:
  - `editing`=1, `field`=01, `time_ow`=1, `time_set`=`time_current` sampled at edge n, all visible after edge n.
- Inc/dec at edge n: the new field value is visible after edge n (1-cycle latency).
- Back-to-back pulses on consecutive cycles are each honoured.
- `btn_mode` in EDIT_S at edge n:
  - After edge n: `editing`=0, `field`=00.
  - `time_ow` stays 1 for exactly `COMMIT_CYCLES` cycles, then drops to 0 together with the return to IDLE.
- A `btn_mode` in the first IDLE cycle after COMMIT starts a new edit normally.

## Test plan
- Basic edit:
  - Stimulus: with `COMMIT_CYCLES`=4, `time_current`=23:48:00, pulse mode, inc×1 in the hour field, mode, dec×1 in the minute field, mode, inc×5 in the second field, mode.
  - Required: `time_set`=00:47:05 (0x00, 0x47, 0x05); `time_ow` high from the first mode+1 until exactly 4 cycles after the last mode; `field` sequence 01,10,11,00.
- Wrap boundaries:
  - Hour: dec from 00 gives 23; inc from 09 gives 10; inc from 19 gives 20.
  - Minute: dec from 00 gives 59; inc from 59 gives 00.
  - Second: inc from 09 gives 10.
- Simultaneous events:
  - `btn_inc`+`btn_dec` together leave the field unchanged.
  - `btn_mode`+`btn_inc` in EDIT_H advances to EDIT_M with the hour unchanged.
  - Inc in IDLE changes nothing.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=10; enter edit and inc the hour once, then stay idle.
  - Required: COMMIT entered exactly 10 cycles after the inc; the edited hour is retained in `time_set`.
- Reset mid-operation:
  - Stimulus: `rst_n`=0 for 1 cycle during EDIT_M, then during COMMIT.
  - Required: in both cases, next cycle state is IDLE, `time_ow`=0, `time_set`=0, `field`=00.
- Integration:
  - Stimulus: drive a clockwork instance on a 10× slower clock; set 12:34:56.
  - Required: the clockwork counts from 12:34:56 after commit; its output does not advance while `editing`=1.
